apb_regbank_slave: RTL

Parametrised APB4 completer with an internal register bank, the successor to the single-transfer APB slave FSM. It decodes its own slice of the APB address map, inserts a configurable number of wait states, applies byte-lane strobes on writes, and reports protection, alignment, range and read-only violations on PSLVERR. It sits on the shared APB bus behind the bridge and exposes its registers and per-register write pulses directly to peripheral logic.

---
 rtl/apb_regbank_slave_pkg.sv | 31 +++
 rtl/apb_regbank_core.sv | 80 ++++++++
 rtl/apb_regbank_slave.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apb_regbank_slave_pkg.sv
// apb_pkg: shared types and helpers for the APB register-bank completer.
//   apb_state_t : completer FSM states
//   ERR_*       : bit positions in the latched error-cause vector
//   apb_geom()  : strobe width and byte-offset bit count for a data width
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_t;

    localparam int ERR_PROT  = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_RANGE = 2;
    localparam int ERR_RO    = 3;
    localparam int ERR_W     = 4;

    typedef struct packed {
        logic [7:0] strb_w;
        logic [7:0] off_bits;
    } apb_geom_t;

    function automatic apb_geom_t apb_geom(input int dw);
        apb_geom_t g;
        g.strb_w   = 8'(dw / 8);
        g.off_bits = 8'($clog2(dw / 8));
        return g;
    endfunction

endpackage

// File: rtl/apb_regbank_core.sv
// apb_regbank_core: register array behind the APB completer.
//   PCLK, PRESETn : clock, async active-low reset
//   i_we          : commit a write this edge to register i_idx
//   i_idx         : write index (latched by the FSM)
//   i_wdata/i_strb: write data and byte-lane enables
//   i_ridx        : combinational read index
//   i_ro          : hardware values for read-only registers
//   o_rdata       : read mux output
//   o_regs        : flattened register contents
//   o_wr_pulse    : one-cycle pulse per register after a committed write
module apb_regbank_core
    import apb_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 NUM_REGS   = 16,
    parameter int                 IDX_W      = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_idx,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_strb,
    input  logic [IDX_W-1:0]               i_ridx,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);

    localparam apb_geom_t GEOM   = apb_geom(DATA_WIDTH);
    localparam int        STRB_W = int'(GEOM.strb_w);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;
    // only the RO slots of i_ro are consumed
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_ro_unused;
    logic [DATA_WIDTH-1:0]               w_rdata;

    assign w_ro_unused = i_ro;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic w_sel;
        logic r_pulse;

        assign w_sel = i_we && (i_idx == IDX_W'(g));

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) r_pulse <= 1'b0;
            else          r_pulse <= w_sel;
        end
        assign o_wr_pulse[g] = r_pulse;

        if (RO_MASK[g]) begin : g_ro
            // no storage: writes are rejected upstream, reads see hardware value
            assign w_regs[g] = w_ro_unused[g];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    r_q <= '0;
                end else if (w_sel) begin
                    for (int b = 0; b < STRB_W; b++)
                        if (i_strb[b]) r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            assign w_regs[g] = r_q;
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (i_ridx == IDX_W'(i)) w_rdata = w_regs[i];
    end

    assign o_rdata = w_rdata;
    assign o_regs  = w_regs;

endmodule

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 completer with an internal register bank.
//   PCLK, PRESETn        : bus clock, async active-low reset
//   PSELx/PENABLE/PWRITE : APB control
//   PADDR/PPROT/PWDATA/PSTRB : APB request
//   PRDATA/PREADY/PSLVERR: registered APB response
//   regs_o   : flattened register contents (reg i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ro_in    : hardware values for RO_MASK registers
//   wr_pulse : one-cycle pulse per register after a committed write
// Decode and error evaluation happen only in the setup cycle; the FSM then
// counts wait states and commits writes on the completing edge.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 16,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter logic [1:0]          SLAVE_SEL   = 2'b00,
    parameter int                  WAIT_STATES = 0,
    parameter bit                  PRIV_ONLY   = 1'b0,
    parameter bit                  SECURE_ONLY = 1'b0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSELx,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [2:0]                     PPROT,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam apb_geom_t             GEOM       = apb_geom(DATA_WIDTH);
    localparam int                    OFFB       = int'(GEOM.off_bits);
    localparam int                    IDX_W      = ADDR_WIDTH - 2 - OFFB;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFFB) - 1);
    localparam logic [IDX_W:0]        NREGS_C    = (IDX_W+1)'(NUM_REGS);

    apb_state_t            r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt, w_idx, w_ridx;
    logic [ERR_W-1:0]      r_err, w_err_nxt, w_err;
    logic                  r_write, w_write_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_slverr, w_slverr_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt, w_rdata;
    logic                  w_hit, w_ro, w_we;
    logic                  w_unused_prot;

    assign w_unused_prot = PPROT[2];

    assign w_hit = PSELx && !PENABLE && (PADDR[ADDR_WIDTH-1 -: 2] == SLAVE_SEL);
    assign w_idx = PADDR[ADDR_WIDTH-3:OFFB];

    always_comb begin
        w_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (RO_MASK[i] && (w_idx == IDX_W'(i))) w_ro = 1'b1;
    end

    assign w_err[ERR_PROT]  = (PRIV_ONLY && !PPROT[0]) || (SECURE_ONLY && PPROT[1]);
    assign w_err[ERR_ALIGN] = |(PADDR & ALIGN_MASK);
    assign w_err[ERR_RANGE] = {1'b0, w_idx} >= NREGS_C;
    assign w_err[ERR_RO]    = PWRITE && w_ro;

    // zero-wait reads are answered on the setup edge, so read from live PADDR there
    assign w_ridx = (r_state == IDLE) ? w_idx : r_idx;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_err_nxt    = r_err;
        w_write_nxt  = r_write;
        w_ready_nxt  = r_ready;
        w_slverr_nxt = r_slverr;
        w_rdata_nxt  = r_rdata;
        w_we         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_idx_nxt   = w_idx;
                    w_err_nxt   = w_err;
                    w_write_nxt = PWRITE;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = READY;
                        w_ready_nxt  = 1'b1;
                        w_slverr_nxt = |w_err;
                        w_rdata_nxt  = (PWRITE || (|w_err)) ? '0 : w_rdata;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!PSELx) begin
                    w_state_nxt  = IDLE;
                    w_ready_nxt  = 1'b0;
                    w_slverr_nxt = 1'b0;
                    w_rdata_nxt  = '0;
                end else if (PENABLE) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt  = READY;
                        w_ready_nxt  = 1'b1;
                        w_slverr_nxt = |r_err;
                        w_rdata_nxt  = (r_write || (|r_err)) ? '0 : w_rdata;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            READY: begin
                // a dropped PSELx here is an aborted transfer: no commit
                w_state_nxt  = IDLE;
                w_ready_nxt  = 1'b0;
                w_slverr_nxt = 1'b0;
                w_rdata_nxt  = '0;
                w_we         = PSELx && r_write && (r_err == '0);
            end
            default: begin
                w_state_nxt  = IDLE;
                w_ready_nxt  = 1'b0;
                w_slverr_nxt = 1'b0;
                w_rdata_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_err    <= '0;
            r_write  <= 1'b0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
            r_write  <= w_write_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign PRDATA  = r_rdata;
    assign PREADY  = r_ready;
    assign PSLVERR = r_slverr;

    apb_regbank_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_core (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .i_we       (w_we),
        .i_idx      (r_idx),
        .i_wdata    (PWDATA),
        .i_strb     (PSTRB),
        .i_ridx     (w_ridx),
        .i_ro       (ro_in),
        .o_rdata    (w_rdata),
        .o_regs     (regs_o),
        .o_wr_pulse (wr_pulse)
    );

endmodule
